lsu_store_queue: RTL and testbench

//   Parametrised store buffer between LSU execute and data RAM. Retires stores in order

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_sq_match.sv | 59 +++++
 rtl/lsu_store_queue.sv | 112 +++++++++++
 tb/tb_lsu_store_queue.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the LSU store queue: access sizes, queue entry layout and
// the byte-lane mask helper used by both storage and lookup logic.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  // Entries are sized for the widest supported configuration; narrower
  // instances only use the low bits.
  localparam int unsigned SQ_AW_MAX = 64;
  localparam int unsigned SQ_DW_MAX = 64;

  typedef struct packed {
    logic                 valid;
    logic [SQ_AW_MAX-1:0] addr;
    logic [SQ_DW_MAX-1:0] data;
    size_e                size;
  } sq_entry_t;

  // Byte lanes touched by an access; a misaligned access spills above the
  // word's lanes and therefore never compares exact against an aligned one.
  function automatic logic [7:0] size_to_mask(input size_e size, input logic [2:0] offset);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/lsu_sq_match.sv
// Store-to-load lookup: scans valid entries oldest to youngest so the last
// exact match seen is the youngest, and flags any partial overlap.
module lsu_sq_match
  import lsu_pkg::*;
#(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  sq_entry_t         i_entries [DEPTH],
  input  logic [PW-1:0]     i_head,
  input  logic              i_ld_valid,
  input  logic [AW-1:0]     i_ld_addr,
  input  logic [1:0]        i_ld_size,
  output logic              o_ld_hit,
  output logic [DW-1:0]     o_ld_hit_data,
  output logic              o_ld_conflict
);

  localparam int unsigned OW = $clog2(DW / 8);

  logic          w_any_exact;
  logic          w_any_partial;
  logic [DW-1:0] w_exact_data;
  logic [7:0]    w_ld_mask;
  logic          w_unused;

  assign w_ld_mask = size_to_mask(size_e'(i_ld_size), 3'(i_ld_addr[OW-1:0]));

  always_comb begin
    logic [PW-1:0] idx;
    logic [7:0]    e_mask;
    logic          same_word;
    w_any_exact   = 1'b0;
    w_any_partial = 1'b0;
    w_exact_data  = '0;
    w_unused      = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx       = i_head + PW'(k);
      e_mask    = size_to_mask(i_entries[idx].size, 3'(i_entries[idx].addr[OW-1:0]));
      same_word = i_entries[idx].addr[AW-1:OW] == i_ld_addr[AW-1:OW];
      w_unused  = w_unused ^ (^{i_entries[k].addr, i_entries[k].data});
      if (i_entries[idx].valid && same_word) begin
        if (e_mask == w_ld_mask) begin
          w_any_exact  = 1'b1;
          w_exact_data = i_entries[idx].data[DW-1:0];
        end else if ((e_mask & w_ld_mask) != 8'h00) begin
          w_any_partial = 1'b1;
        end
      end
    end
  end

  assign o_ld_conflict = i_ld_valid && w_any_partial;
  assign o_ld_hit      = i_ld_valid && !w_any_partial && w_any_exact;
  assign o_ld_hit_data = o_ld_hit ? w_exact_data : '0;

endmodule

// File: rtl/lsu_store_queue.sv
// In-order store buffer between LSU execute and data RAM: holds stores,
// retires the head over a req/ack handshake and serves load forwarding.
module lsu_store_queue
  import lsu_pkg::*;
#(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_st_valid,
  input  logic [AW-1:0] i_st_addr,
  input  logic [DW-1:0] i_st_data,
  input  logic [1:0]    i_st_size,
  output logic          o_st_ready,
  input  logic          i_ld_valid,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [1:0]    i_ld_size,
  output logic          o_ld_hit,
  output logic [DW-1:0] o_ld_hit_data,
  output logic          o_ld_conflict,
  output logic          o_mem_req,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_data,
  output logic [1:0]    o_mem_size,
  input  logic          i_mem_ack,
  output logic          o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {ST_IDLE, ST_REQ} state_e;

  sq_entry_t       r_entries [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  state_e          r_state;
  state_e          w_state_next;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_count_next;

  assign o_st_ready   = r_count < CW'(DEPTH);
  assign o_empty      = r_count == '0;
  assign w_push       = i_st_valid && o_st_ready;
  assign w_pop        = (r_state == ST_REQ) && i_mem_ack;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  assign o_mem_req  = r_state == ST_REQ;
  assign o_mem_addr = o_mem_req ? r_entries[r_head].addr[AW-1:0] : '0;
  assign o_mem_data = o_mem_req ? r_entries[r_head].data[DW-1:0] : '0;
  assign o_mem_size = o_mem_req ? r_entries[r_head].size : 2'b00;

  // Looking at the post-push count lets a store into an empty queue be
  // requested on the very next cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_count_next != '0) w_state_next = ST_REQ;
      ST_REQ:  if (w_pop && w_count_next == '0) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: only the valid bits are reset; address/data payloads are never read
  // while invalid, so clearing them would just add reset fan-out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_entries[i].valid <= 1'b0;
    end else begin
      if (w_pop) begin
        r_entries[r_head].valid <= 1'b0;
        r_head                  <= r_head + PW'(1);
      end
      if (w_push) begin
        r_entries[r_tail] <= '{valid: 1'b1,
                               addr:  SQ_AW_MAX'(i_st_addr),
                               data:  SQ_DW_MAX'(i_st_data),
                               size:  size_e'(i_st_size)};
        r_tail            <= r_tail + PW'(1);
      end
      r_count <= w_count_next;
    end
  end

  lsu_sq_match #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_match (
    .i_entries     (r_entries),
    .i_head        (r_head),
    .i_ld_valid    (i_ld_valid),
    .i_ld_addr     (i_ld_addr),
    .i_ld_size     (i_ld_size),
    .o_ld_hit      (o_ld_hit),
    .o_ld_hit_data (o_ld_hit_data),
    .o_ld_conflict (o_ld_conflict)
  );

endmodule

// File: tb/tb_lsu_store_queue.sv
// Directed self-checking bench for lsu_store_queue (AW=32, DW=32, DEPTH=4).
module tb_lsu_store_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic        ld_hit;
  logic [31:0] ld_hit_data;
  logic        ld_conflict;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [1:0]  mem_size;
  logic        mem_ack;
  logic        empty;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  lsu_store_queue #(.AW(32), .DW(32), .DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_st_valid    (st_valid),
    .i_st_addr     (st_addr),
    .i_st_data     (st_data),
    .i_st_size     (st_size),
    .o_st_ready    (st_ready),
    .i_ld_valid    (ld_valid),
    .i_ld_addr     (ld_addr),
    .i_ld_size     (ld_size),
    .o_ld_hit      (ld_hit),
    .o_ld_hit_data (ld_hit_data),
    .o_ld_conflict (ld_conflict),
    .o_mem_req     (mem_req),
    .o_mem_addr    (mem_addr),
    .o_mem_data    (mem_data),
    .o_mem_size    (mem_size),
    .i_mem_ack     (mem_ack),
    .o_empty       (empty)
  );

  typedef struct {
    logic        vld;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        hit;
    logic        conf;
    logic [31:0] data;
  } ld_vec_t;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %b, expected %b", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  // Inputs change 2 time units after the rising edge; registered outputs are settled then.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    st_valid = 1'b1; st_addr = a; st_data = d; st_size = s;
    step();
    st_valid = 1'b0;
  endtask

  task automatic lookup(input logic v, input logic [31:0] a, input logic [1:0] s);
    ld_valid = v; ld_addr = a; ld_size = s;
    #1;
  endtask

  ld_vec_t     vecs [11];
  logic [31:0] exp_addr [4];
  logic [31:0] exp_data [4];
  logic [1:0]  exp_size [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = 2'b10;
    ld_valid = 1'b0; ld_addr = '0; ld_size = 2'b10; mem_ack = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state
    lookup(1'b1, 32'h100, 2'b10);
    check_bit ("rst_mem_req", mem_req, 1'b0);
    check_word("rst_mem_addr", mem_addr, 32'h0);
    check_word("rst_mem_data", mem_data, 32'h0);
    check_bit ("rst_st_ready", st_ready, 1'b1);
    check_bit ("rst_empty", empty, 1'b1);
    check_bit ("rst_ld_hit", ld_hit, 1'b0);
    check_bit ("rst_ld_conflict", ld_conflict, 1'b0);
    check_word("rst_ld_hit_data", ld_hit_data, 32'h0);
    ld_valid = 1'b0;

    // Single store, ack after 3 cycles
    push(32'h100, 32'hDEADBEEF, 2'b10);
    for (int c = 0; c < 3; c++) begin
      check_bit ($sformatf("t1_req_c%0d", c), mem_req, 1'b1);
      check_word($sformatf("t1_addr_c%0d", c), mem_addr, 32'h100);
      check_word($sformatf("t1_data_c%0d", c), mem_data, 32'hDEADBEEF);
      check_bit ($sformatf("t1_empty_c%0d", c), empty, 1'b0);
      if (c < 2) step();
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check_bit("t1_req_after_ack", mem_req, 1'b0);
    check_bit("t1_empty_after_ack", empty, 1'b1);

    // Fill, overflow attempt, in-order drain with back-to-back acks
    for (int i = 0; i < 4; i++) begin
      check_bit($sformatf("t2_ready_before_%0d", i), st_ready, 1'b1);
      push(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 2'b10);
    end
    check_bit("t2_ready_full", st_ready, 1'b0);
    push(32'h110, 32'hBAD, 2'b10);
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_bit ($sformatf("t2_req_%0d", i), mem_req, 1'b1);
      check_word($sformatf("t2_addr_%0d", i), mem_addr, 32'h100 + 32'(4 * i));
      check_word($sformatf("t2_data_%0d", i), mem_data, 32'hA0 + 32'(i));
      step();
    end
    mem_ack = 1'b0;
    check_bit("t2_empty_drained", empty, 1'b1);
    check_bit("t2_req_drained", mem_req, 1'b0);

    // Forwarding / conflict table against a held, full queue
    push(32'h200, 32'h11111111, 2'b10);
    push(32'h200, 32'h22222222, 2'b10);
    push(32'h301, 32'h000000AB, 2'b00);
    push(32'h406, 32'h0000BEEF, 2'b01);
    vecs[0]  = '{1'b1, 32'h200, 2'b10, 1'b1, 1'b0, 32'h22222222};
    vecs[1]  = '{1'b1, 32'h201, 2'b00, 1'b0, 1'b1, 32'h0};
    vecs[2]  = '{1'b1, 32'h300, 2'b10, 1'b0, 1'b1, 32'h0};
    vecs[3]  = '{1'b1, 32'h302, 2'b00, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 32'h301, 2'b00, 1'b1, 1'b0, 32'h000000AB};
    vecs[5]  = '{1'b1, 32'h406, 2'b01, 1'b1, 1'b0, 32'h0000BEEF};
    vecs[6]  = '{1'b1, 32'h404, 2'b01, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 32'h404, 2'b10, 1'b0, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 32'h500, 2'b00, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h200, 2'b10, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 32'h204, 2'b10, 1'b0, 1'b0, 32'h0};
    check_bit("t3_ready_full", st_ready, 1'b0);
    for (int i = 0; i < 11; i++) begin
      lookup(vecs[i].vld, vecs[i].addr, vecs[i].size);
      check_bit ($sformatf("lk%0d_hit", i), ld_hit, vecs[i].hit);
      check_bit ($sformatf("lk%0d_conflict", i), ld_conflict, vecs[i].conf);
      check_word($sformatf("lk%0d_data", i), ld_hit_data, vecs[i].data);
    end
    ld_valid = 1'b0;
    exp_addr = '{32'h200, 32'h200, 32'h301, 32'h406};
    exp_data = '{32'h11111111, 32'h22222222, 32'h000000AB, 32'h0000BEEF};
    exp_size = '{2'b10, 2'b10, 2'b00, 2'b01};
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_word($sformatf("t3_drain_addr_%0d", i), mem_addr, exp_addr[i]);
      check_word($sformatf("t3_drain_data_%0d", i), mem_data, exp_data[i]);
      check_word($sformatf("t3_drain_size_%0d", i), 32'(mem_size), 32'(exp_size[i]));
      step();
    end
    mem_ack = 1'b0;
    check_bit("t3_empty", empty, 1'b1);

    // Full queue: push dropped during ack, then push+pop keeps count
    for (int i = 0; i < 4; i++) push(32'h600 + 32'(4 * i), 32'h600 + 32'(4 * i), 2'b10);
    st_valid = 1'b1; st_addr = 32'h700; st_data = 32'h700; st_size = 2'b10; mem_ack = 1'b1;
    #1;
    check_bit("t5_ready_full_ack_cycle", st_ready, 1'b0);
    step();
    st_valid = 1'b0; mem_ack = 1'b0;
    check_bit ("t5_ready_after_pop", st_ready, 1'b1);
    check_word("t5_head_after_pop", mem_addr, 32'h604);
    st_valid = 1'b1; st_addr = 32'h710; st_data = 32'h710; mem_ack = 1'b1;
    step();
    st_valid = 1'b0; mem_ack = 1'b0;
    check_bit ("t5_ready_push_pop", st_ready, 1'b1);
    check_word("t5_head_push_pop", mem_addr, 32'h608);
    push(32'h720, 32'h720, 2'b10);
    check_bit("t5_ready_refull", st_ready, 1'b0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check_word("t5_head_3_left", mem_addr, 32'h60C);
    lookup(1'b1, 32'h710, 2'b10);
    check_bit ("t5_fwd_710_hit", ld_hit, 1'b1);
    check_word("t5_fwd_710_data", ld_hit_data, 32'h710);
    lookup(1'b1, 32'h700, 2'b10);
    check_bit("t5_dropped_700_absent", ld_hit, 1'b0);

    // Reset with a request outstanding and 3 entries queued
    check_bit("t6_req_before_rst", mem_req, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    lookup(1'b1, 32'h710, 2'b10);
    check_bit("t6_req_after_rst", mem_req, 1'b0);
    check_bit("t6_empty_after_rst", empty, 1'b1);
    check_bit("t6_ready_after_rst", st_ready, 1'b1);
    check_bit("t6_entry_discarded", ld_hit, 1'b0);
    step();
    check_bit("t6_req_stays_low", mem_req, 1'b0);
    ld_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
